// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_pkg
// Purpose  : Shared definitions for the alarm clock entry path. It holds the
//            controller state encoding, the 24-hour BCD digit limits, and a
//            helper that decides whether a key is valid for a buffer position.
// Revision : 1.0  initial release
// ============================================================================
package alarm_clock_pkg;

    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

    // 24-hour limits for HH:MM entry
    localparam bcd_t MAX_MS_HR       = 4'd2;   // tens of hours
    localparam bcd_t MAX_LS_HR_AT_20 = 4'd3;   // hours digit when tens of hours is 2
    localparam bcd_t MAX_MS_MIN      = 4'd5;   // tens of minutes
    localparam bcd_t MAX_DIGIT       = 4'd9;   // any other BCD digit

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHOW_ALARM = 3'd1,
        ST_ENTRY      = 3'd2,
        ST_WAIT_CMD   = 3'd3,
        ST_LOAD_TIME  = 3'd4,
        ST_LOAD_ALARM = 3'd5
    } state_t;

    // Returns 1 when code is a legal digit for buffer position pos. The
    // hours digit depends on the tens-of-hours digit already stored (d0).
    function automatic logic digit_ok(input logic [1:0] pos,
                                      input bcd_t       d0,
                                      input bcd_t       code);
        logic ok;
        ok = 1'b0;
        case (pos)
            2'd0:    ok = (code <= MAX_MS_HR);
            2'd1:    ok = (d0 == MAX_MS_HR) ? (code <= MAX_LS_HR_AT_20)
                                            : (code <= MAX_DIGIT);
            2'd2:    ok = (code <= MAX_MS_MIN);
            default: ok = (code <= MAX_DIGIT);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/entry_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : entry_digit_buffer
// Purpose  : Four-digit BCD store for HH:MM entry. It checks each offered key
//            against the limits for the next free position and stores it when
//            legal, then advances the write index.
// Ports    : clk, reset (async, active-high)
//            key_valid_i  offered key (already gated by the controller)
//            key_code_i   BCD code of the offered key
//            clear_i      empty the buffer and rewind the index (has priority)
//            accept_o     offered key is legal and is stored at the next edge
//            last_o       the next accepted key fills the final position
//            digitN_o     stored digits, 0 = tens of hours .. 3 = minutes
// Revision : 1.0  initial release
// ============================================================================
module entry_digit_buffer
    import alarm_clock_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic key_valid_i,
    input  bcd_t key_code_i,
    input  logic clear_i,
    output logic accept_o,
    output logic last_o,
    output bcd_t digit0_o,
    output bcd_t digit1_o,
    output bcd_t digit2_o,
    output bcd_t digit3_o
);

    bcd_t [3:0] digit_q;
    logic [1:0] idx_q;

    assign accept_o = key_valid_i && digit_ok(idx_q, digit_q[0], key_code_i);
    assign last_o   = (idx_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
            idx_q   <= 2'd0;
        end else if (clear_i) begin
            digit_q <= '0;
            idx_q   <= 2'd0;
        end else if (accept_o) begin
            digit_q[idx_q] <= key_code_i;
            idx_q          <= idx_q + 2'd1;
        end
    end

    assign digit0_o = digit_q[0];
    assign digit1_o = digit_q[1];
    assign digit2_o = digit_q[2];
    assign digit3_o = digit_q[3];

endmodule
`default_nettype wire

// File: rtl/alarm_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_entry_ctrl
// Purpose  : Keypad/button sequencer for the alarm clock. It collects four
//            validated BCD digits (HH:MM), then on a button commits them to
//            the time counter or the alarm register with a one-cycle strobe.
//            It drives the display-select flags and abandons an entry that
//            has been idle for TIMEOUT_S seconds.
// Ports    : clk, reset (async, active-high)
//            one_second      1-cycle pulse per second
//            key_valid       1-cycle strobe, key_code holds a key press
//            key_code        BCD digit (10..15 are never accepted)
//            time_button     level, commit to current time
//            alarm_button    level, commit to alarm / show alarm from idle
//            load_new_c/a    1-cycle load strobes (time / alarm)
//            show_new_time   display shows the entry buffer
//            show_a          display shows the alarm time
//            reset_count     1-cycle pulse after every accepted key
//            new_time_*      entry buffer digits
// Revision : 1.0  initial release
// ============================================================================
module alarm_entry_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int TIMEOUT_S = 10,
    parameter int TO_W      = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       time_button,
    input  logic       alarm_button,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_a,
    output logic       reset_count,
    output logic [3:0] new_time_ms_hr,
    output logic [3:0] new_time_ls_hr,
    output logic [3:0] new_time_ms_min,
    output logic [3:0] new_time_ls_min
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_S - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic load_c_q, load_c_d;
    logic load_a_q, load_a_d;
    logic show_new_q, show_new_d;
    logic show_a_q, show_a_d;
    logic rst_cnt_q, rst_cnt_d;

    logic w_buf_key_valid;
    logic w_buf_clear;
    logic w_accept;
    logic w_last;

    entry_digit_buffer u_buf (
        .clk         (clk),
        .reset       (reset),
        .key_valid_i (w_buf_key_valid),
        .key_code_i  (key_code),
        .clear_i     (w_buf_clear),
        .accept_o    (w_accept),
        .last_o      (w_last),
        .digit0_o    (new_time_ms_hr),
        .digit1_o    (new_time_ls_hr),
        .digit2_o    (new_time_ms_min),
        .digit3_o    (new_time_ls_min)
    );

    always_comb begin
        state_d         = state_q;
        to_cnt_d        = to_cnt_q;
        w_buf_key_valid = 1'b0;
        w_buf_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Time button is deliberately ignored here so a button still
                // held after a load cannot retrigger anything.
                w_buf_key_valid = key_valid;
                if (w_accept) begin
                    state_d  = ST_ENTRY;
                    to_cnt_d = '0;
                end else if (alarm_button) begin
                    state_d = ST_SHOW_ALARM;
                end
            end

            ST_SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ENTRY: begin
                w_buf_key_valid = key_valid;
                // An accepted key beats a simultaneous timeout expiry.
                if (w_accept) begin
                    to_cnt_d = '0;
                    if (w_last) begin
                        state_d = ST_WAIT_CMD;
                    end
                end else if (one_second) begin
                    if (to_cnt_q == c_to_last) begin
                        state_d     = ST_IDLE;
                        to_cnt_d    = '0;
                        w_buf_clear = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            ST_WAIT_CMD: begin
                if (time_button) begin
                    state_d = ST_LOAD_TIME;
                end else if (alarm_button) begin
                    state_d = ST_LOAD_ALARM;
                end else if (one_second) begin
                    if (to_cnt_q == c_to_last) begin
                        state_d     = ST_IDLE;
                        to_cnt_d    = '0;
                        w_buf_clear = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            ST_LOAD_TIME, ST_LOAD_ALARM: begin
                // Buffer stays stable during the strobe and empties after it.
                state_d     = ST_IDLE;
                to_cnt_d    = '0;
                w_buf_clear = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                to_cnt_d    = '0;
                w_buf_clear = 1'b1;
            end
        endcase

        // Outputs are registered versions of the next-state decode, so they
        // change on the same edge as the state itself.
        load_c_d   = (state_d == ST_LOAD_TIME);
        load_a_d   = (state_d == ST_LOAD_ALARM);
        show_new_d = (state_d == ST_ENTRY) || (state_d == ST_WAIT_CMD);
        show_a_d   = (state_d == ST_SHOW_ALARM);
        rst_cnt_d  = w_accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            load_c_q   <= 1'b0;
            load_a_q   <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
            rst_cnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            load_c_q   <= load_c_d;
            load_a_q   <= load_a_d;
            show_new_q <= show_new_d;
            show_a_q   <= show_a_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    assign load_new_c    = load_c_q;
    assign load_new_a    = load_a_q;
    assign show_new_time = show_new_q;
    assign show_a        = show_a_q;
    assign reset_count   = rst_cnt_q;

endmodule
`default_nettype wire
